// File: rtl/rv32i_defs.sv
// Shared load/store definitions for the rv32i core: memory access unit
// codes, request/response bundles and small lane helpers.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 10
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

package rv32i_defs;

    localparam logic [1:0] BYTE_MEMORY_MODE     = 2'b00;
    localparam logic [1:0] HALFWORD_MEMORY_MODE = 2'b01;
    localparam logic [1:0] WORD_MEMORY_MODE     = 2'b10;
    localparam logic [1:0] MEM_UNIT_ILLEGAL     = 2'b11;

    typedef struct packed {
        logic        we;
        logic [1:0]  unit;
        logic        is_unsigned;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } mem_rsp_t;

    // Byte-lane mask of an access before it is shifted to its address offset
    function automatic logic [3:0] mem_unit_mask(input logic [1:0] unit);
        case (unit)
            BYTE_MEMORY_MODE:     return 4'b0001;
            HALFWORD_MEMORY_MODE: return 4'b0011;
            WORD_MEMORY_MODE:     return 4'b1111;
            default:              return 4'b0000;
        endcase
    endfunction

    // True when the access spills past the end of its 32-bit word
    function automatic logic mem_is_crossing(input logic [1:0] unit, input logic [1:0] off);
        return ((unit == HALFWORD_MEMORY_MODE) && (off == 2'b11)) ||
               ((unit == WORD_MEMORY_MODE) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word-organised RAM with per-byte write enables and a registered read port.
module mem_word_array #(
    parameter int    WADDR_WIDTH = 8,
    parameter string INIT_FILE   = ""
) (
    input  logic                   clk,
    input  logic                   i_we,
    input  logic [3:0]             i_be,
    input  logic [WADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]            i_wdata,
    output logic [31:0]            o_rdata
);

    logic [31:0] r_mem [0:(1 << WADDR_WIDTH)-1];
    logic [31:0] r_rdata;

    // Byte-masked write and synchronous read (old data on same-edge collision)
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_memory_ctrl.sv
// Handshaked data memory for the rv32i load/store path: lane steering,
// optional split of word-crossing accesses, load extension and a
// configurable-latency response pipeline.
module data_memory_ctrl
    import rv32i_defs::*;
#(
    parameter int    ADDR_WIDTH       = `ADDR_WIDTH,
    parameter int    WORD_WIDTH       = `WORD_WIDTH,
    parameter int    READ_LATENCY     = 1,
    parameter bit    ALLOW_MISALIGNED = 1'b0,
    parameter string INIT_FILE        = "dmem.hex"
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_unit,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WORD_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [WORD_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int WA_W = ADDR_WIDTH - 2;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SPLIT = 1'b1;

    if ((READ_LATENCY < 1) || (READ_LATENCY > 4)) begin : g_bad_latency
        $error("data_memory_ctrl: READ_LATENCY must lie in 1..4");
    end
    if (WORD_WIDTH != 32) begin : g_bad_width
        $error("data_memory_ctrl: WORD_WIDTH must be 32");
    end

    // Gathered lanes to the architectural load value
    function automatic logic [31:0] mem_extend(input logic [31:0] d, input logic [1:0] unit,
                                               input logic is_uns);
        case (unit)
            BYTE_MEMORY_MODE:     return {{24{~is_uns & d[7]}}, d[7:0]};
            HALFWORD_MEMORY_MODE: return {{16{~is_uns & d[15]}}, d[15:0]};
            default:              return d;
        endcase
    endfunction

    logic [0:0]      r_state;
    logic            r_sp_we;
    logic [WA_W-1:0] r_sp_word;
    logic [3:0]      r_sp_be;
    logic [31:0]     r_sp_wdata;
    logic [31:0]     r_lo;
    logic            r_a_vld;
    logic            r_a_split;
    logic [1:0]      r_a_off;
    logic [1:0]      r_a_unit;
    logic            r_a_uns;
    logic            r_a_zero;
    logic            r_a_err;
    logic [READ_LATENCY-1:0] r_vld;
    mem_rsp_t        r_pipe [0:READ_LATENCY-1];

    logic [1:0]      w_off;
    logic [WA_W-1:0] w_word;
    logic            w_accept;
    logic            w_cross;
    logic            w_err;
    logic            w_split;
    logic [7:0]      w_be8;
    logic [63:0]     w_wdata64;
    logic            w_arr_we;
    logic [3:0]      w_arr_be;
    logic [WA_W-1:0] w_arr_addr;
    logic [31:0]     w_arr_wdata;
    logic [31:0]     w_arr_rdata;
    logic [63:0]     w_gather;
    logic [31:0]     w_lane;
    mem_rsp_t        w_rsp;

    assign req_ready = (r_state == S_IDLE);
    assign w_off     = req_addr[1:0];
    assign w_word    = req_addr[ADDR_WIDTH-1:2];
    assign w_accept  = req_valid && req_ready;
    assign w_cross   = mem_is_crossing(req_unit, w_off);
    // An illegal unit is never crossing, so it cannot start a split
    assign w_err     = (req_unit == MEM_UNIT_ILLEGAL) || (w_cross && !ALLOW_MISALIGNED);
    assign w_split   = w_cross && ALLOW_MISALIGNED;
    assign w_be8     = {4'b0000, mem_unit_mask(req_unit)} << w_off;
    assign w_wdata64 = {32'h0, req_wdata} << {w_off, 3'b000};

    // Array port steering: request word while idle, following word during SPLIT
    always_comb begin
        w_arr_we    = w_accept && req_we && !w_err;
        w_arr_be    = w_be8[3:0];
        w_arr_addr  = w_word;
        w_arr_wdata = w_wdata64[31:0];
        if (r_state == S_SPLIT) begin
            w_arr_we    = r_sp_we;
            w_arr_be    = r_sp_be;
            w_arr_addr  = r_sp_word + WA_W'(1);
            w_arr_wdata = r_sp_wdata;
        end
    end

    mem_word_array #(
        .WADDR_WIDTH (WA_W),
        .INIT_FILE   (INIT_FILE)
    ) u_array (
        .clk     (clk),
        .i_we    (w_arr_we),
        .i_be    (w_arr_be),
        .i_addr  (w_arr_addr),
        .i_wdata (w_arr_wdata),
        .o_rdata (w_arr_rdata)
    );

    // FSM and "last array access done" valid; reset drops a pending upper half
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_sp_we   <= 1'b0;
            r_a_vld   <= 1'b0;
            r_a_split <= 1'b0;
        end else begin
            r_a_split <= (r_state == S_SPLIT);
            case (r_state)
                S_IDLE: begin
                    r_a_vld <= w_accept && !w_split;
                    if (w_accept && w_split) begin
                        r_state <= S_SPLIT;
                        r_sp_we <= req_we;
                    end
                end
                default: begin
                    r_a_vld <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Request metadata, upper-half store lanes and the held lower read word
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a_off    <= w_off;
            r_a_unit   <= req_unit;
            r_a_uns    <= req_unsigned;
            r_a_zero   <= req_we || w_err;
            r_a_err    <= w_err;
            r_sp_word  <= w_word;
            r_sp_be    <= w_be8[7:4];
            r_sp_wdata <= w_wdata64[63:32];
        end
        if (r_state == S_SPLIT) r_lo <= w_arr_rdata;
    end

    // Lane gather across one or two words, then extension
    always_comb begin
        w_gather  = r_a_split ? {w_arr_rdata, r_lo} : {32'h0, w_arr_rdata};
        w_lane    = 32'(w_gather >> {r_a_off, 3'b000});
        w_rsp     = '0;
        w_rsp.err = r_a_err;
        if (!r_a_zero) w_rsp.rdata = mem_extend(w_lane, r_a_unit, r_a_uns);
    end

    // Response latency pipeline; idle slots carry zero so outputs rest at 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) r_pipe[i] <= '0;
        end else begin
            r_vld[0]  <= r_a_vld;
            r_pipe[0] <= r_a_vld ? w_rsp : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign rsp_valid = r_vld[READ_LATENCY-1];
    assign rsp_rdata = r_pipe[READ_LATENCY-1].rdata;
    assign rsp_err   = r_pipe[READ_LATENCY-1].err;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench: unit A is strict (errors on crossing, latency 1),
// unit B splits crossing accesses with latency 3.
module tb_data_memory_ctrl;
    import rv32i_defs::*;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    typedef struct {
        int          id;
        logic [31:0] d;
        logic        e;
        int          c;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    int          n_id = 0;
    exp_t        q_a[$];
    exp_t        q_b[$];

    logic        a_rst_n, a_req_valid, a_req_ready, a_req_we, a_req_unsigned;
    logic [1:0]  a_req_unit;
    logic [9:0]  a_req_addr;
    logic [31:0] a_req_wdata, a_rsp_rdata;
    logic        a_rsp_valid, a_rsp_err;
    logic        b_rst_n, b_req_valid, b_req_ready, b_req_we, b_req_unsigned;
    logic [1:0]  b_req_unit;
    logic [9:0]  b_req_addr;
    logic [31:0] b_req_wdata, b_rsp_rdata;
    logic        b_rsp_valid, b_rsp_err;

    data_memory_ctrl #(
        .ADDR_WIDTH(10), .WORD_WIDTH(32), .READ_LATENCY(LAT_A),
        .ALLOW_MISALIGNED(1'b0), .INIT_FILE("")
    ) dut_a (
        .clk(clk), .rst_n(a_rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_we(a_req_we), .req_unit(a_req_unit), .req_unsigned(a_req_unsigned),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .rsp_valid(a_rsp_valid),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    data_memory_ctrl #(
        .ADDR_WIDTH(10), .WORD_WIDTH(32), .READ_LATENCY(LAT_B),
        .ALLOW_MISALIGNED(1'b1), .INIT_FILE("")
    ) dut_b (
        .clk(clk), .rst_n(b_rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_we(b_req_we), .req_unit(b_req_unit), .req_unsigned(b_req_unsigned),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, req);
        end
    endtask

    task automatic take_rsp(input bit sel, input logic [31:0] d, input logic e);
        exp_t x;
        string u;
        u = sel ? "B" : "A";
        if ((sel && q_b.size() == 0) || (!sel && q_a.size() == 0)) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s unexpected rsp at cycle %0d: got data 0x%08h err %0d, required none",
                     u, cyc, d, e);
            return;
        end
        if (sel) x = q_b.pop_front();
        else     x = q_a.pop_front();
        chk($sformatf("%s rsp#%0d rdata", u, x.id), d, x.d);
        chk($sformatf("%s rsp#%0d err", u, x.id), 32'(e), 32'(x.e));
        chk($sformatf("%s rsp#%0d cycle", u, x.id), 32'(cyc), 32'(x.c));
    endtask

    // Monitors: pop and compare whenever a response pulse is presented
    always @(negedge clk) if (a_rsp_valid) take_rsp(1'b0, a_rsp_rdata, a_rsp_err);
    always @(negedge clk) if (b_rsp_valid) take_rsp(1'b1, b_rsp_rdata, b_rsp_err);

    task automatic issue(input bit sel, input logic we, input logic [1:0] unit, input logic uns,
                         input logic [9:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_d, input logic exp_e,
                         input bit split, input bit push);
        exp_t x;
        int   guard;
        guard = 0;
        while (!(sel ? b_req_ready : a_req_ready)) begin
            @(posedge clk); #1;
            guard++;
            if (guard > 20) begin
                n_vec++;
                n_bad++;
                $display("FAIL %s req_ready wait: got 0, required 1 within 20 cycles", sel ? "B" : "A");
                break;
            end
        end
        if (sel) begin
            b_req_valid = 1'b1; b_req_we = we; b_req_unit = unit;
            b_req_unsigned = uns; b_req_addr = addr; b_req_wdata = wd;
        end else begin
            a_req_valid = 1'b1; a_req_we = we; a_req_unit = unit;
            a_req_unsigned = uns; a_req_addr = addr; a_req_wdata = wd;
        end
        @(posedge clk); #1;
        if (sel) b_req_valid = 1'b0;
        else     a_req_valid = 1'b0;
        if (push) begin
            n_id++;
            x.id = n_id;
            x.d  = exp_d;
            x.e  = exp_e;
            x.c  = cyc + (sel ? LAT_B : LAT_A) + (split ? 1 : 0);
            if (sel) q_b.push_back(x);
            else     q_a.push_back(x);
        end
        if (split) chk($sformatf("B req_ready in SPLIT after @0x%03h", addr), 32'(b_req_ready), 32'd0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && guard < 30) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("outstanding responses after drain", 32'(q_a.size() + q_b.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        a_rst_n = 1'b0; a_req_valid = 1'b0; a_req_we = 1'b0; a_req_unit = 2'b00;
        a_req_unsigned = 1'b0; a_req_addr = '0; a_req_wdata = '0;
        b_rst_n = 1'b0; b_req_valid = 1'b0; b_req_we = 1'b0; b_req_unit = 2'b00;
        b_req_unsigned = 1'b0; b_req_addr = '0; b_req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("A reset rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("A reset rsp_rdata", a_rsp_rdata, 32'd0);
        chk("A reset rsp_err", 32'(a_rsp_err), 32'd0);
        chk("A reset req_ready", 32'(a_req_ready), 32'd1);
        chk("B reset rsp_valid", 32'(b_rsp_valid), 32'd0);
        chk("B reset req_ready", 32'(b_req_ready), 32'd1);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        @(posedge clk); #1;

        // Unit A: stores, extension, read-after-write, non-crossing misaligned
        issue(0, 1, WORD_MEMORY_MODE,     0, 10'h010, 32'hDEADBEEF, 32'h0,        0, 0, 1);
        issue(0, 0, BYTE_MEMORY_MODE,     0, 10'h013, 32'h0,        32'hFFFFFFDE, 0, 0, 1);
        issue(0, 0, HALFWORD_MEMORY_MODE, 1, 10'h012, 32'h0,        32'h0000DEAD, 0, 0, 1);
        issue(0, 0, HALFWORD_MEMORY_MODE, 0, 10'h012, 32'h0,        32'hFFFFDEAD, 0, 0, 1);
        issue(0, 0, BYTE_MEMORY_MODE,     1, 10'h010, 32'h0,        32'h000000EF, 0, 0, 1);
        issue(0, 0, HALFWORD_MEMORY_MODE, 1, 10'h011, 32'h0,        32'h0000ADBE, 0, 0, 1);
        issue(0, 1, BYTE_MEMORY_MODE,     0, 10'h011, 32'hFFFFFF5A, 32'h0,        0, 0, 1);
        issue(0, 1, HALFWORD_MEMORY_MODE, 0, 10'h012, 32'hFFFF1234, 32'h0,        0, 0, 1);
        issue(0, 0, WORD_MEMORY_MODE,     0, 10'h010, 32'h0,        32'h12345AEF, 0, 0, 1);
        issue(0, 0, BYTE_MEMORY_MODE,     0, 10'h011, 32'h0,        32'h0000005A, 0, 0, 1);
        // Unit A: error responses leave the array untouched
        issue(0, 1, WORD_MEMORY_MODE,     0, 10'h020, 32'hCAFEF00D, 32'h0,        0, 0, 1);
        issue(0, 0, WORD_MEMORY_MODE,     0, 10'h022, 32'h0,        32'h0,        1, 0, 1);
        issue(0, 0, MEM_UNIT_ILLEGAL,     0, 10'h000, 32'h0,        32'h0,        1, 0, 1);
        issue(0, 1, WORD_MEMORY_MODE,     0, 10'h021, 32'hFFFFFFFF, 32'h0,        1, 0, 1);
        issue(0, 1, MEM_UNIT_ILLEGAL,     0, 10'h020, 32'hFFFFFFFF, 32'h0,        1, 0, 1);
        issue(0, 1, HALFWORD_MEMORY_MODE, 0, 10'h023, 32'hFFFFFFFF, 32'h0,        1, 0, 1);
        issue(0, 0, WORD_MEMORY_MODE,     0, 10'h020, 32'h0,        32'hCAFEF00D, 0, 0, 1);
        drain();

        // Unit B: split store/load across words 0x20/0x24
        issue(1, 1, WORD_MEMORY_MODE,     0, 10'h020, 32'hA0A1A2A3, 32'h0,        0, 0, 1);
        issue(1, 1, WORD_MEMORY_MODE,     0, 10'h024, 32'hB0B1B2B3, 32'h0,        0, 0, 1);
        issue(1, 1, WORD_MEMORY_MODE,     0, 10'h021, 32'h11223344, 32'h0,        0, 1, 1);
        issue(1, 0, WORD_MEMORY_MODE,     0, 10'h021, 32'h0,        32'h11223344, 0, 1, 1);
        issue(1, 0, WORD_MEMORY_MODE,     0, 10'h020, 32'h0,        32'h223344A3, 0, 0, 1);
        issue(1, 0, WORD_MEMORY_MODE,     0, 10'h024, 32'h0,        32'hB0B1B211, 0, 0, 1);
        issue(1, 0, HALFWORD_MEMORY_MODE, 0, 10'h023, 32'h0,        32'h00001122, 0, 1, 1);
        issue(1, 1, WORD_MEMORY_MODE,     0, 10'h028, 32'h01020304, 32'h0,        0, 0, 1);
        issue(1, 1, WORD_MEMORY_MODE,     0, 10'h02C, 32'h85060708, 32'h0,        0, 0, 1);
        drain();
        // Unit B: back-to-back aligned loads produce back-to-back responses
        issue(1, 0, WORD_MEMORY_MODE,     0, 10'h020, 32'h0,        32'h223344A3, 0, 0, 1);
        issue(1, 0, WORD_MEMORY_MODE,     0, 10'h024, 32'h0,        32'hB0B1B211, 0, 0, 1);
        issue(1, 0, WORD_MEMORY_MODE,     0, 10'h028, 32'h0,        32'h01020304, 0, 0, 1);
        issue(1, 0, WORD_MEMORY_MODE,     0, 10'h02C, 32'h0,        32'h85060708, 0, 0, 1);
        issue(1, 0, BYTE_MEMORY_MODE,     0, 10'h02F, 32'h0,        32'hFFFFFF85, 0, 0, 1);
        drain();

        // Unit B: reset during the SPLIT cycle of a wrapping store
        issue(1, 1, WORD_MEMORY_MODE,     0, 10'h000, 32'h77665544, 32'h0,        0, 0, 1);
        issue(1, 1, WORD_MEMORY_MODE,     0, 10'h3FC, 32'h99887766, 32'h0,        0, 0, 1);
        drain();
        issue(1, 0, WORD_MEMORY_MODE,     0, 10'h000, 32'h0,        32'h0,        0, 0, 0);
        b_req_valid = 1'b1; b_req_we = 1'b1; b_req_unit = WORD_MEMORY_MODE;
        b_req_unsigned = 1'b0; b_req_addr = 10'h3FD; b_req_wdata = 32'hAABBCCDD;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        chk("B req_ready in SPLIT before reset", 32'(b_req_ready), 32'd0);
        b_rst_n = 1'b0;
        #1;
        chk("B mid-split reset rsp_valid", 32'(b_rsp_valid), 32'd0);
        chk("B mid-split reset rsp_rdata", b_rsp_rdata, 32'd0);
        chk("B mid-split reset rsp_err", 32'(b_rsp_err), 32'd0);
        chk("B mid-split reset req_ready", 32'(b_req_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        b_rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        issue(1, 0, WORD_MEMORY_MODE,     0, 10'h000, 32'h0,        32'h77665544, 0, 0, 1);
        issue(1, 0, WORD_MEMORY_MODE,     0, 10'h3FC, 32'h0,        32'hBBCCDD66, 0, 0, 1);
        issue(1, 0, BYTE_MEMORY_MODE,     1, 10'h3FF, 32'h0,        32'h000000BB, 0, 0, 1);
        issue(1, 0, WORD_MEMORY_MODE,     0, 10'h3FD, 32'h0,        32'h44BBCCDD, 0, 1, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
